// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the bus arbiter: transfer encodings, arbiter states,
// and the index-width helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_PARK = 2'b00,
        ST_OWN  = 2'b01,
        ST_LOCK = 2'b10
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting just after last, wrapping,
// so the previous owner ends up with the lowest priority.
module rr_pick
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned IW             = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last,
    output logic [IW-1:0]          winner,
    output logic                   no_req
);

    logic [IW-1:0] idx;

    // Scan from the far end back toward last+1 so the nearest requester is written last.
    always_comb begin
        winner = IW'(DEFAULT_MASTER);
        no_req = 1'b1;
        idx    = '0;
        for (int unsigned k = NUM_MASTERS; k > 0; k--) begin
            idx = IW'((32'(last) + k) % NUM_MASTERS);
            if (req[idx]) begin
                winner = idx;
                no_req = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter in front of the APB bridge: registered one-hot grant,
// locked sequences, park master and a fairness hold limit; hready_in low freezes all.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 16
) (
    input  logic                                  hclk,
    input  logic                                  hresetn,
    input  logic [NUM_MASTERS-1:0]                hbusreq,
    input  logic [NUM_MASTERS-1:0]                hlock,
    input  logic [1:0]                            htrans,
    input  logic                                  hready_in,
    output logic [NUM_MASTERS-1:0]                hgrant,
    output logic [idx_width(NUM_MASTERS)-1:0]     hmaster,
    output logic                                  hmastlock
);

    localparam int unsigned IW = idx_width(NUM_MASTERS);
    localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    arb_state_e state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] last_owner, last_owner_n;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic [NUM_MASTERS-1:0] grant_n;
    logic [IW-1:0] winner;
    logic no_req;
    logic boundary;
    logic others_req;

    rr_pick #(
        .NUM_MASTERS   (NUM_MASTERS),
        .DEFAULT_MASTER(DEFAULT_MASTER),
        .IW            (IW)
    ) u_pick (
        .req   (hbusreq),
        .last  (last_owner),
        .winner(winner),
        .no_req(no_req)
    );

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        hold_cnt_n   = hold_cnt;
        grant_n      = '0;
        others_req   = |(hbusreq & ~hgrant);

        if (state == ST_LOCK) begin
            boundary = hready_in && !hlock[owner];
        end else begin
            boundary = hready_in && ((htrans == HTRANS_IDLE) || !hbusreq[owner] ||
                                     (hold_cnt == HOLD_LIMIT));
        end

        if (boundary) begin
            if (no_req) begin
                if (state != ST_PARK) begin
                    owner_n    = DEF_IDX;
                    state_n    = ST_PARK;
                    hold_cnt_n = '0;
                end
            end else begin
                owner_n      = winner;
                last_owner_n = winner;
                hold_cnt_n   = '0;
                state_n      = hlock[winner] ? ST_LOCK : ST_OWN;
            end
        end else if (hready_in && state == ST_OWN && others_req && hold_cnt < HOLD_LIMIT) begin
            hold_cnt_n = hold_cnt + 8'd1;
        end

        grant_n[owner_n] = 1'b1;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= ST_PARK;
            owner      <= DEF_IDX;
            last_owner <= DEF_IDX;
            hold_cnt   <= '0;
            hgrant     <= DEF_GRANT;
            hmaster    <= DEF_IDX;
            hmastlock  <= 1'b0;
        end else if (hready_in) begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            hold_cnt   <= hold_cnt_n;
            hgrant     <= grant_n;
            hmaster    <= owner;
            hmastlock  <= (state == ST_LOCK);
        end
    end

endmodule
